// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory and the decoder.
// master = fetch unit side, slave = memory/decoder environment side.
interface fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned INSTR_WIDTH = 16
);
    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   instr_ready;

    logic                   load_pc;
    logic [ADDR_WIDTH-1:0]  load_pc_val;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  load_pc, load_pc_val
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output load_pc, load_pc_val
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and
// presents each instruction to the decoder, honouring jump redirects.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH  = 12,
    parameter int unsigned           INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  r_target;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0]  r_instr_pc;

    logic                   w_ack;
    logic                   w_redirect;
    logic [ADDR_WIDTH-1:0]  w_pc_inc;

    always_comb begin
        w_ack      = bus.imem_ack;
        w_redirect = bus.load_pc;
        w_pc_inc   = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                w_next_state = FETCH;
            end
            FETCH: begin
                if (w_redirect) begin
                    // Without the ack a request is still in flight and must be drained.
                    w_next_state = w_ack ? FETCH : FLUSH;
                end else if (w_ack) begin
                    w_next_state = VALID;
                end
            end
            VALID: begin
                if (w_redirect || bus.instr_ready) begin
                    w_next_state = FETCH;
                end
            end
            FLUSH: begin
                if (w_ack) begin
                    w_next_state = FETCH;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_target   <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_redirect) begin
                        if (w_ack) begin
                            r_pc <= bus.load_pc_val;
                        end else begin
                            r_target <= bus.load_pc_val;
                        end
                    end else if (w_ack) begin
                        r_instr    <= bus.imem_rdata;
                        r_instr_pc <= r_pc;
                        r_pc       <= w_pc_inc;
                    end
                end
                VALID: begin
                    if (w_redirect) begin
                        r_pc <= bus.load_pc_val;
                    end
                end
                FLUSH: begin
                    if (w_ack) begin
                        r_pc <= w_redirect ? bus.load_pc_val : r_target;
                    end else if (w_redirect) begin
                        r_target <= bus.load_pc_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.imem_req    = (r_state == FETCH) || (r_state == FLUSH);
        bus.imem_addr   = r_pc;
        bus.instr_valid = (r_state == VALID);
        bus.instr       = r_instr;
        bus.instr_pc    = r_instr_pc;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural model of the fetch stage.
module tb_fetch_unit;

    localparam int unsigned AW = 12;
    localparam int unsigned IW = 16;

    logic clk;
    logic rst;

    fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    fetch_unit #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .RESET_PC   (12'h000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp;
    int n_err;

    // Behavioural model: tracks what the stage is doing in terms of
    // "starting up / request in flight / request is stale / instruction held".
    bit            m_boot;
    bit            m_busy;
    bit            m_drop;
    bit            m_hold;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_tgt;
    logic [IW-1:0] m_i;
    logic [AW-1:0] m_ipc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return 16'h1000 + {4'h0, a};
    endfunction

    task automatic model_reset();
        m_boot = 1'b1;
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_hold = 1'b0;
        m_pc   = 12'h000;
        m_tgt  = 12'h000;
        m_i    = 16'h0000;
        m_ipc  = 12'h000;
    endtask

    task automatic model_step(input bit ack, input bit rdy, input bit lp, input logic [AW-1:0] lpv);
        if (m_boot) begin
            m_boot = 1'b0;
            m_busy = 1'b1;
        end else if (m_busy && !m_drop) begin
            if (lp) begin
                if (ack) m_pc = lpv;
                else begin
                    m_drop = 1'b1;
                    m_tgt  = lpv;
                end
            end else if (ack) begin
                m_hold = 1'b1;
                m_i    = mem_word(m_pc);
                m_ipc  = m_pc;
                m_pc   = m_pc + 12'h001;
                m_busy = 1'b0;
            end
        end else if (m_busy) begin
            if (ack) begin
                m_pc   = lp ? lpv : m_tgt;
                m_drop = 1'b0;
            end else if (lp) begin
                m_tgt = lpv;
            end
        end else if (m_hold) begin
            if (lp || rdy) begin
                if (lp) m_pc = lpv;
                m_hold = 1'b0;
                m_busy = 1'b1;
            end
        end
    endtask

    // Drives one cycle of inputs from the falling edge, advances the model at
    // the rising edge and returns at the next falling edge.
    task automatic tick(input bit ack, input bit rdy, input bit lp, input logic [AW-1:0] lpv);
        bus.imem_ack    = ack;
        bus.imem_rdata  = ack ? mem_word(m_pc) : 16'($urandom);
        bus.instr_ready = rdy;
        bus.load_pc     = lp;
        bus.load_pc_val = lpv;
        @(posedge clk);
        model_step(ack, rdy, lp, lpv);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
        bus.load_pc = 1'b0; bus.load_pc_val = '0;
        model_reset();
        #2;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 12'h000) begin n_err++; $display("FAIL rst_addr: got %h want 000", bus.imem_addr); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
        n_cmp++; if (bus.instr !== 16'h0000) begin n_err++; $display("FAIL rst_instr: got %h want 0000", bus.instr); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_idle_req: got %b want 0", bus.imem_req); end
    endtask

    task automatic test_zero_wait();
        tick(1'b0, 1'b1, 1'b0, 12'h000);
        for (int unsigned k = 0; k < 6; k++) begin
            n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'(k) || bus.instr_valid !== 1'b0) begin
                n_err++; $display("FAIL zw_fetch[%0d]: got req=%b addr=%h valid=%b want req=1 addr=%h valid=0",
                                  k, bus.imem_req, bus.imem_addr, bus.instr_valid, 12'(k));
            end
            tick(1'b1, 1'b1, 1'b0, 12'h000);
            n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h1000 + 16'(k) || bus.instr_pc !== 12'(k) || bus.imem_req !== 1'b0) begin
                n_err++; $display("FAIL zw_valid[%0d]: got valid=%b instr=%h pc=%h req=%b want valid=1 instr=%h pc=%h req=0",
                                  k, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req, 16'h1000 + 16'(k), 12'(k));
            end
            tick(1'b0, 1'b1, 1'b0, 12'h000);
        end
    endtask

    task automatic test_wait_states();
        logic [AW-1:0] a;
        a = 12'h006;
        for (int unsigned i = 0; i < 4; i++) begin
            n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== a || bus.instr_valid !== 1'b0) begin
                n_err++; $display("FAIL ws_hold[%0d]: got req=%b addr=%h valid=%b want req=1 addr=%h valid=0",
                                  i, bus.imem_req, bus.imem_addr, bus.instr_valid, a);
            end
            tick(i == 3, 1'b1, 1'b0, 12'h000);
        end
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h1006 || bus.instr_pc !== a) begin
            n_err++; $display("FAIL ws_valid: got valid=%b instr=%h pc=%h want valid=1 instr=1006 pc=%h",
                              bus.instr_valid, bus.instr, bus.instr_pc, a);
        end
    endtask

    task automatic test_backpressure();
        for (int unsigned i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b0, 12'h000);
            n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h1006 || bus.instr_pc !== 12'h006 || bus.imem_req !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d]: got valid=%b instr=%h pc=%h req=%b want valid=1 instr=1006 pc=006 req=0",
                                  i, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req);
            end
        end
        tick(1'b0, 1'b1, 1'b0, 12'h000);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h007 || bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_release: got req=%b addr=%h valid=%b want req=1 addr=007 valid=0",
                              bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
    endtask

    task automatic test_redirect_valid();
        tick(1'b1, 1'b1, 1'b0, 12'h000);
        tick(1'b0, 1'b0, 1'b1, 12'h0A5);
        n_cmp++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h0A5) begin
            n_err++; $display("FAIL rv_jump: got valid=%b req=%b addr=%h want valid=0 req=1 addr=0a5",
                              bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
        tick(1'b1, 1'b1, 1'b0, 12'h000);
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 12'h0A5 || bus.instr !== 16'h10A5) begin
            n_err++; $display("FAIL rv_target: got valid=%b pc=%h instr=%h want valid=1 pc=0a5 instr=10a5",
                              bus.instr_valid, bus.instr_pc, bus.instr);
        end
        tick(1'b0, 1'b1, 1'b0, 12'h000);
    endtask

    task automatic test_redirect_flush();
        // Redirect coinciding with the ack: data dropped, refetch from 0x010.
        tick(1'b1, 1'b1, 1'b1, 12'h010);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h010 || bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL rf_ackjump: got req=%b addr=%h valid=%b want req=1 addr=010 valid=0",
                              bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        tick(1'b0, 1'b1, 1'b1, 12'h200);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h010 || bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL rf_flush: got req=%b addr=%h valid=%b want req=1 addr=010 valid=0",
                              bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        tick(1'b0, 1'b1, 1'b0, 12'h000);
        tick(1'b1, 1'b1, 1'b0, 12'h000);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h200 || bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL rf_newaddr: got req=%b addr=%h valid=%b want req=1 addr=200 valid=0",
                              bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
        tick(1'b1, 1'b1, 1'b0, 12'h000);
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 12'h200) begin
            n_err++; $display("FAIL rf_instr: got valid=%b pc=%h want valid=1 pc=200", bus.instr_valid, bus.instr_pc);
        end
        tick(1'b0, 1'b1, 1'b0, 12'h000);
        tick(1'b0, 1'b1, 1'b1, 12'h250);
        tick(1'b0, 1'b1, 1'b1, 12'h300);
        n_cmp++; if (bus.imem_addr !== 12'h201 || bus.imem_req !== 1'b1) begin
            n_err++; $display("FAIL rf_flush2: got req=%b addr=%h want req=1 addr=201", bus.imem_req, bus.imem_addr);
        end
        tick(1'b1, 1'b1, 1'b0, 12'h000);
        n_cmp++; if (bus.imem_addr !== 12'h300 || bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL rf_second: got addr=%h valid=%b want addr=300 valid=0", bus.imem_addr, bus.instr_valid);
        end
        tick(1'b0, 1'b1, 1'b1, 12'h111);
        tick(1'b1, 1'b1, 1'b1, 12'h155);
        n_cmp++; if (bus.imem_addr !== 12'h155 || bus.imem_req !== 1'b1) begin
            n_err++; $display("FAIL rf_ackredir: got req=%b addr=%h want req=1 addr=155", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_wrap_reset();
        tick(1'b1, 1'b1, 1'b1, 12'hFFF);
        tick(1'b1, 1'b1, 1'b0, 12'h000);
        n_cmp++; if (bus.instr_pc !== 12'hFFF || bus.instr !== 16'h1FFF || bus.imem_addr !== 12'h000) begin
            n_err++; $display("FAIL wrap: got pc=%h instr=%h addr=%h want pc=fff instr=1fff addr=000",
                              bus.instr_pc, bus.instr, bus.imem_addr);
        end
        tick(1'b0, 1'b1, 1'b0, 12'h000);
        tick(1'b0, 1'b1, 1'b1, 12'h123);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 12'h000) begin
            n_err++; $display("FAIL midrst: got req=%b valid=%b addr=%h want req=0 valid=0 addr=000",
                              bus.imem_req, bus.instr_valid, bus.imem_addr);
        end
        bus.load_pc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick(1'b0, 1'b1, 1'b0, 12'h000);
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h000) begin
            n_err++; $display("FAIL restart: got req=%b addr=%h want req=1 addr=000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_random();
        bit            ack;
        bit            rdy;
        bit            lp;
        logic [AW-1:0] lpv;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int unsigned c = 0; c < 3000; c++) begin
            n_cmp++; if (bus.imem_req !== m_busy || bus.imem_addr !== m_pc || bus.instr_valid !== m_hold) begin
                n_err++; $display("FAIL rnd_ctl[%0d]: got req=%b addr=%h valid=%b want req=%b addr=%h valid=%b",
                                  c, bus.imem_req, bus.imem_addr, bus.instr_valid, m_busy, m_pc, m_hold);
            end
            if (m_hold) begin
                n_cmp++; if (bus.instr !== m_i || bus.instr_pc !== m_ipc) begin
                    n_err++; $display("FAIL rnd_data[%0d]: got instr=%h pc=%h want instr=%h pc=%h",
                                      c, bus.instr, bus.instr_pc, m_i, m_ipc);
                end
            end
            ack = m_busy && ($urandom_range(0, 99) < 45);
            rdy = $urandom_range(0, 99) < 70;
            lp  = $urandom_range(0, 99) < 12;
            lpv = 12'($urandom);
            if ($urandom_range(0, 99) < 3) lpv = 12'hFFF;
            tick(ack, rdy, lp, lpv);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_backpressure();
        test_redirect_valid();
        test_redirect_flush();
        test_wrap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit microcpu; sits directly upstream of the instruction decoder/control unit. Holds the program counter, issues one read at a time to instruction memory over a req/ack handshake, and presents each fetched instruction with its address on a valid/ready interface. Accepts the decoder's jump redirect (`load_pc`/`load_pc_val`) and discards any fetch made obsolete by it.

## Interface
- `ADDR_WIDTH`, 12: PC and instruction-memory address width; matches the 12-bit jump target.
- `INSTR_WIDTH`, 16: instruction word width.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  ADDR_WIDTH  read address; equals the PC register.
- `imem_ack`  in  1  read complete; `imem_rdata` is valid in this cycle.
- `imem_rdata`  in  INSTR_WIDTH  instruction word returned by memory.
- `instr_valid`  out  1  `instr`/`instr_pc` hold a fetched instruction.
- `instr`  out  INSTR_WIDTH  fetched instruction, driven to the decoder.
- `instr_pc`  out  ADDR_WIDTH  address the instruction was fetched from.
- `instr_ready`  in  1  decoder accepts `instr` in this cycle.
- `load_pc`  in  1  jump redirect from the decoder.
- `load_pc_val`  in  ADDR_WIDTH  jump target.

## Operation
- Registered state: `pc`, `state`, `instr`, `instr_pc`, `target` (pending redirect). States: IDLE, FETCH, VALID, FLUSH.
- Reset (async): state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, target=0. Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0.
- `imem_req`=1 exactly in FETCH and FLUSH. `instr_valid`=1 exactly in VALID. Both are decoded from the registered state only.
- IDLE: go unconditionally to FETCH on the next edge.
- FETCH, no redirect, `imem_ack`=1:
  - `instr`<=`imem_rdata`, `instr_pc`<=`pc`.
  - `pc`<=`pc`+1 modulo 2^ADDR_WIDTH; 0xFFF wraps to 0x000.
  - Go to VALID.
- FETCH, no ack: hold. `imem_req` and `imem_addr` stay stable until ack. This stability is a hard handshake rule.
- VALID, `instr_ready`=1, no redirect: go to FETCH.
- VALID, `instr_ready`=0: hold all registers.
- Redirect in VALID: `pc`<=`load_pc_val`, go to FETCH. The buffered instruction is dropped whether or not `instr_ready` is set. The jump instruction itself is the one presented, so it is treated as consumed.
- Redirect in FETCH with `imem_ack`=1 in the same cycle: discard `imem_rdata`, `pc`<=`load_pc_val`, stay in FETCH.
- Redirect in FETCH without ack: `target`<=`load_pc_val`, go to FLUSH. `imem_addr` keeps the old pc.
- FLUSH: a further redirect overwrites `target`.
  - On `imem_ack`: discard the data; `pc`<=`target`, or `load_pc_val` if a redirect occurs in that same cycle; go to FETCH.
- Never more than one outstanding memory request.
- Redirect in IDLE is ignored.

## Timing
- Clock and reset:
  - Single clock domain.
  - Reset asserts asynchronously.
  - The first edge after `rst` deasserts moves IDLE→FETCH, so `imem_req` first rises one cycle after reset release.
- Fetch throughput:
  - Zero-wait memory (ack in the same cycle as req) with `instr_ready` held high gives one instruction every 2 cycles.
  - Each memory wait state adds one cycle.
  - Fetch-to-valid latency is 1 edge after the ack.
- Redirect:
  - A redirect takes effect at the next edge.
  - The new address appears on `imem_addr` one cycle after `load_pc`, unless the FSM is in FLUSH waiting for the stale ack.
- `instr`/`instr_pc` are stable for the whole time `instr_valid`=1.

## Test plan
- Reset, then zero-wait memory returning `mem[a]=0x1000+a`, ready=1:
  - imem_addr sequence 0,1,2,…
  - instr 0x1000,0x1001,… with matching instr_pc.
  - instr_valid high every other cycle.
- Memory acks 3 cycles after req:
  - imem_req/imem_addr stay constant for all 3 cycles.
  - instr_valid rises 1 cycle after the ack.
- Backpressure, instr_ready=0 for 5 cycles while VALID:
  - instr/instr_pc/instr_valid are held.
  - imem_req stays 0.
  - The next fetch starts one cycle after ready=1.
- Redirect in VALID with `load_pc_val`=0x0A5, ready=0:
  - instr_valid drops next cycle.
  - imem_addr=0x0A5.
  - The next instr_pc is 0x0A5.
- Redirect to 0x200 during a 2-cycle-wait fetch of 0x010:
  - The ack data for 0x010 never appears on instr_valid.
  - The next imem_addr is 0x200.
  - Repeat with a second redirect to 0x300 while in FLUSH; the next imem_addr is 0x300.
- Wrap-around and mid-operation reset:
  - A fetch at 0xFFF is followed by imem_addr 0x000.
  - Asserting rst while in FLUSH immediately gives imem_req=0 and instr_valid=0.
  - After release, fetch restarts at RESET_PC.
